// File: rtl/async_sync_pkg.sv
// Shared constants and helpers for the multi-channel async-input synchronizer/filter.
package async_sync_pkg;

    localparam int SYNC_STAGE_MIN    = 2;
    localparam int FILTER_CYCLES_MIN = 1;

    function automatic int clog2(input int value);
        int res;
        int x;
        res = 0;
        x   = value - 1;
        while (x > 0) begin
            res = res + 1;
            x   = x >> 1;
        end
        return res;
    endfunction

    // The counter needs at least one bit, even when the filter is disabled.
    function automatic int cnt_width(input int filter_cycles);
        return (clog2(filter_cycles) < 1) ? 1 : clog2(filter_cycles);
    endfunction

    function automatic bit params_ok(input int num_ch, input int sync_stage,
                                     input int filter_cycles);
        return (num_ch >= 1) && (sync_stage >= SYNC_STAGE_MIN) &&
               (filter_cycles >= FILTER_CYCLES_MIN);
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchronizer chain, stability counter, filtered level and edge pulses.
module sync_filter_ch
    import async_sync_pkg::*;
#(
    parameter int   SYNC_STAGE    = 3,
    parameter int   FILTER_CYCLES = 4,
    parameter logic INIT_VAL      = 1'b0
) (
    input  logic clk_sync,
    input  logic rst_sync,
    input  logic data_in,
    input  logic bypass,
    output logic data_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] FULL_THR_M1 = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGE-1:0] sync_q;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      thr_m1;
    logic                  sync_raw;

    assign sync_raw = sync_q[SYNC_STAGE-1];
    assign thr_m1   = bypass ? '0 : FULL_THR_M1;

    // ">=" so that bypass rising mid-pending accepts the differing sample at once.
    always_ff @(posedge clk_sync) begin
        if (rst_sync) begin
            sync_q     <= {SYNC_STAGE{INIT_VAL}};
            data_out   <= INIT_VAL;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGE-2:0], data_in};
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (sync_raw == data_out) begin
                cnt <= '0;
            end else if (cnt >= thr_m1) begin
                data_out   <= sync_raw;
                cnt        <= '0;
                rise_pulse <= sync_raw;
                fall_pulse <= ~sync_raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_sync_filter_mc.sv
// NUM_CH independent synchronizer/glitch-filter channels with rise/fall pulses.
module async_sync_filter_mc
    import async_sync_pkg::*;
#(
    parameter int                NUM_CH           = 4,
    parameter int                SYNC_STAGE       = 3,
    parameter int                FILTER_CYCLES    = 4,
    parameter logic [NUM_CH-1:0] RESET_INIT_VALUE = '0
) (
    input  logic              clk_sync,
    input  logic              rst_sync,
    input  logic [NUM_CH-1:0] data_in,
    input  logic [NUM_CH-1:0] bypass,
    output logic [NUM_CH-1:0] data_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              change_any
);

    if (!params_ok(NUM_CH, SYNC_STAGE, FILTER_CYCLES)) begin : g_param_err
        $error("async_sync_filter_mc: illegal NUM_CH/SYNC_STAGE/FILTER_CYCLES");
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sync_filter_ch #(
            .SYNC_STAGE   (SYNC_STAGE),
            .FILTER_CYCLES(FILTER_CYCLES),
            .INIT_VAL     (RESET_INIT_VALUE[g])
        ) u_ch (
            .clk_sync  (clk_sync),
            .rst_sync  (rst_sync),
            .data_in   (data_in[g]),
            .bypass    (bypass[g]),
            .data_out  (data_out[g]),
            .rise_pulse(rise_pulse[g]),
            .fall_pulse(fall_pulse[g])
        );
    end

    assign change_any = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_async_sync_filter_mc.sv
// Randomized scoreboard bench: a sample-history reference model predicts every cycle's outputs.
module tb_async_sync_filter_mc;

    localparam int         NUM_CH        = 4;
    localparam int         SYNC_STAGE    = 3;
    localparam int         FILTER_CYCLES = 4;
    localparam logic [3:0] INIT          = 4'b0101;
    localparam int         N_CYCLES      = 4000;

    logic              clk_sync = 1'b0;
    logic              rst_sync;
    logic [NUM_CH-1:0] data_in;
    logic [NUM_CH-1:0] bypass;
    logic [NUM_CH-1:0] data_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic              change_any;

    always #5 clk_sync = ~clk_sync;

    async_sync_filter_mc #(
        .NUM_CH          (NUM_CH),
        .SYNC_STAGE      (SYNC_STAGE),
        .FILTER_CYCLES   (FILTER_CYCLES),
        .RESET_INIT_VALUE(INIT)
    ) dut (
        .clk_sync  (clk_sync),
        .rst_sync  (rst_sync),
        .data_in   (data_in),
        .bypass    (bypass),
        .data_out  (data_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .change_any(change_any)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] dout;
        logic [NUM_CH-1:0] rise;
        logic [NUM_CH-1:0] fall;
        logic              chg;
    } resp_t;

    resp_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: delay line for the synchronizer, plus the recent
    // synchronized-sample history per channel. A new level is accepted when the
    // last thr samples all disagree with the current output.
    logic [NUM_CH-1:0] m_pipe [SYNC_STAGE];
    logic [NUM_CH-1:0] m_out;
    bit                m_hist [NUM_CH][$];

    task automatic model_edge(output resp_t r);
        logic [NUM_CH-1:0] raw;
        int                thr;
        bit                ok;
        r = '0;
        if (rst_sync) begin
            for (int i = 0; i < SYNC_STAGE; i++) m_pipe[i] = INIT;
            m_out = INIT;
            for (int c = 0; c < NUM_CH; c++) m_hist[c].delete();
            r.dout = m_out;
            return;
        end
        raw = m_pipe[SYNC_STAGE-1];
        for (int c = 0; c < NUM_CH; c++) begin
            m_hist[c].push_back(raw[c]);
            if (m_hist[c].size() > FILTER_CYCLES) void'(m_hist[c].pop_front());
            thr = bypass[c] ? 1 : FILTER_CYCLES;
            ok  = (m_hist[c].size() >= thr);
            for (int k = 0; k < thr && ok; k++)
                if (m_hist[c][m_hist[c].size()-1-k] == m_out[c]) ok = 0;
            if (ok) begin
                if (m_out[c]) r.fall[c] = 1'b1;
                else          r.rise[c] = 1'b1;
                m_out[c] = ~m_out[c];
            end
        end
        for (int i = SYNC_STAGE-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = data_in;
        r.dout = m_out;
        r.chg  = |{r.rise, r.fall};
    endtask

    // Monitor: every cycle with an outstanding expectation is compared.
    initial begin
        resp_t e;
        resp_t a;
        forever begin
            @(posedge clk_sync);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{dout: data_out, rise: rise_pulse, fall: fall_pulse, chg: change_any};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_out t=%0t: got dout=%b rise=%b fall=%b chg=%b, expected dout=%b rise=%b fall=%b chg=%b",
                             $time, a.dout, a.rise, a.fall, a.chg, e.dout, e.rise, e.fall, e.chg);
                end
            end
        end
    end

    // Stimulus: reset with data_in opposite to the init value, then random
    // toggles of varying widths, occasional bypass changes and resets.
    initial begin
        resp_t r;
        int    slow;
        rst_sync = 1'b1;
        data_in  = 4'b1010;
        bypass   = '0;
        slow     = 0;
        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk_sync);
            if (i >= 2) rst_sync = ($urandom_range(0, 79) == 0);
            if (i >= 14) begin
                if (i % 200 == 0) slow = $urandom_range(0, 1);
                for (int c = 0; c < NUM_CH; c++)
                    if ($urandom_range(0, slow ? 9 : 3) == 0) data_in[c] = ~data_in[c];
                if ($urandom_range(0, 99) == 0) bypass = NUM_CH'($urandom());
            end
            model_edge(r);
            exp_q.push_back(r);
        end
        @(posedge clk_sync);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
